// File: rtl/mi_pkg.sv
// Shared definitions for the modular-inverse scheduler: FSM encoding and
// default engine geometry.
package mi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_COLLECT = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int MI_K_DEFAULT = 128;
  localparam int MI_N_DEFAULT = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester found when
// searching upward from last+1 (mod NREQ). Purely combinational.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [NREQ-1:0]         gnt
);

  logic found;

  // Scan offsets 1..NREQ from the last winner; first active request wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int off = 1; off <= NREQ; off++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (((int'(last) + off) % NREQ) == j)) begin
          gnt[j] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mi_sched.sv
// Shares one word-serial modular inverse engine between NREQ requesters:
// grants round-robin, streams operands LSW first, gathers result words and
// returns the assembled inverse, with a watchdog that resets a stuck engine.
module mi_sched
  import mi_pkg::*;
#(
  parameter int          K       = MI_K_DEFAULT,
  parameter int          N       = MI_N_DEFAULT,
  parameter int          NREQ    = 2,
  parameter logic [31:0] TIMEOUT = 32'd1_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*K*N-1:0]   req_a,
  input  logic [NREQ*K*N-1:0]   req_p,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [K*N-1:0]        rsp_r,
  output logic                  rsp_err,
  output logic                  mi_start,
  output logic                  mi_valid_in,
  output logic [K-1:0]          mi_a,
  output logic [K-1:0]          mi_p,
  input  logic [K-1:0]          mi_r,
  input  logic                  mi_valid_out,
  output logic                  eng_rst
);

  localparam int KN = K * N;
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  state_t            state_q, state_d;
  logic [IW-1:0]     last_q, last_d, owner_q, owner_d;
  logic [KN-1:0]     a_sh_q, a_sh_d, p_sh_q, p_sh_d, res_q, res_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [31:0]       tmo_q, tmo_d, tmo_inc;
  logic [NREQ-1:0]   req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [KN-1:0]     rsp_r_q, rsp_r_d;
  logic              rsp_err_q, rsp_err_d, eng_rst_q, eng_rst_d;
  logic              mi_start_q, mi_start_d, mi_valid_in_q, mi_valid_in_d;
  logic [K-1:0]      mi_a_q, mi_a_d, mi_p_q, mi_p_d;

  logic [NREQ-1:0]   gnt, owner_hot;
  logic              acc;
  logic [IW-1:0]     acc_idx;
  logic [KN-1:0]     a_sel, p_sel;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_owner
    assign owner_hot[gi] = (owner_q == IW'(gi));
  end

  assign tmo_inc = (tmo_q == 32'hFFFF_FFFF) ? tmo_q : tmo_q + 32'd1;

  // Decode the handshake: which requester (if any) is accepted this cycle.
  always_comb begin
    acc     = 1'b0;
    acc_idx = '0;
    a_sel   = '0;
    p_sel   = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (req_valid[j] && req_ready_q[j]) begin
        acc     = 1'b1;
        acc_idx = IW'(j);
        a_sel   = req_a[j*KN +: KN];
        p_sel   = req_p[j*KN +: KN];
      end
    end
  end

  // Next-state and next-output logic; outputs are derived from the next state.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    a_sh_d    = a_sh_q;
    p_sh_d    = p_sh_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    tmo_d     = tmo_q;
    rsp_r_d   = rsp_r_q;
    rsp_err_d = rsp_err_q;
    eng_rst_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          a_sh_d  = a_sel;
          p_sh_d  = p_sel;
          owner_d = acc_idx;
          last_d  = acc_idx;
          state_d = ST_START;
        end
      end
      ST_START: begin
        cnt_d   = '0;
        res_d   = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = ST_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT, ST_COLLECT: begin
        tmo_d = tmo_inc;
        if (mi_valid_out) begin
          res_d[int'(cnt_q)*K +: K] = mi_r;
          cnt_d   = cnt_q + 1'b1;
          state_d = ST_COLLECT;
          if (cnt_q == CNT_LAST) begin
            state_d   = ST_DONE;
            rsp_r_d   = res_d;
            rsp_err_d = 1'b0;
          end
        end
        // A finished result in the same cycle wins over the watchdog.
        if (state_d != ST_DONE && tmo_inc == TIMEOUT - 32'd1) begin
          state_d   = ST_DONE;
          rsp_r_d   = '0;
          rsp_err_d = 1'b1;
          eng_rst_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    req_ready_d   = (state_d == ST_IDLE) ? gnt : '0;
    rsp_valid_d   = (state_d == ST_DONE) ? owner_hot : '0;
    mi_start_d    = (state_d == ST_START);
    mi_valid_in_d = (state_d == ST_LOAD);
    mi_a_d        = (state_d == ST_LOAD) ? a_sh_d[int'(cnt_d)*K +: K] : '0;
    mi_p_d        = (state_d == ST_LOAD) ? p_sh_d[int'(cnt_d)*K +: K] : '0;
  end

  // State and registered outputs; reset abandons any job in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_q        <= LAST_RST;
      owner_q       <= '0;
      a_sh_q        <= '0;
      p_sh_q        <= '0;
      res_q         <= '0;
      cnt_q         <= '0;
      tmo_q         <= '0;
      req_ready_q   <= '0;
      rsp_valid_q   <= '0;
      rsp_r_q       <= '0;
      rsp_err_q     <= 1'b0;
      eng_rst_q     <= 1'b0;
      mi_start_q    <= 1'b0;
      mi_valid_in_q <= 1'b0;
      mi_a_q        <= '0;
      mi_p_q        <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      a_sh_q        <= a_sh_d;
      p_sh_q        <= p_sh_d;
      res_q         <= res_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_r_q       <= rsp_r_d;
      rsp_err_q     <= rsp_err_d;
      eng_rst_q     <= eng_rst_d;
      mi_start_q    <= mi_start_d;
      mi_valid_in_q <= mi_valid_in_d;
      mi_a_q        <= mi_a_d;
      mi_p_q        <= mi_p_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_r       = rsp_r_q;
  assign rsp_err     = rsp_err_q;
  assign eng_rst     = eng_rst_q;
  assign mi_start    = mi_start_q;
  assign mi_valid_in = mi_valid_in_q;
  assign mi_a        = mi_a_q;
  assign mi_p        = mi_p_q;

endmodule
